tt_sweep_checker: RTL and testbench
===================================

# tt_sweep_checker

Response-side companion to the exhaustive 3-input truth-table bench. It drives every input vector (x,y,z = 000..111) into a combinational function under test, waits a programmable settle time, and samples the function output `f_in` into a captured truth table. It then compares the captured table against an expected table and reports pass/fail with the lowest failing index. It sits beside any combinational lab block as a synthesizable self-check, replacing manual reading of `$monitor` output.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured in IDLE or DONE only.
- `exp_table`  in  8  expected output; bit i = f for vector i. Latched at accepted start.
- `f_in`  in  1  output of the function under test.
- `x`, `y`, `z`  out  1 each  drive vector; x = vec[2], y = vec[1], z = vec[0].
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  high in DONE; held until next accepted start or reset.
- `pass`  out  1  valid when done; 1 iff captured table == latched expected.
- `tt_out`  out  8  captured table; bit i = sampled f for vector i.
- `fail_valid`  out  1  valid when done; 1 iff any mismatch.
- `first_fail`  out  3  lowest mismatching vector index; 0 when fail_valid = 0.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE --start--> SETTLE: vec = 0, settle counter = 0, tt_out = 0, fail_valid = 0, first_fail = 0, exp_table latched.
- SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE (one cycle): tt_out[vec] <= f_in; if f_in != exp_latched[vec] and fail_valid = 0, set fail_valid = 1 and first_fail = vec. If vec == 7 → DONE, else vec = vec + 1, counter = 0, → SETTLE.
- DONE: outputs frozen; `pass` = ~fail_valid. start → restart exactly as from IDLE.
- start while busy: ignored, no effect on vec, table or latched expected.
- exp_table changes after start: ignored for the current sweep.
- vec never wraps within a sweep; sweep terminates at 7.
- In IDLE, x/y/z = 0.

## Timing
- Reset values: x = y = z = 0, busy = 0, done = 0, pass = 0, tt_out = 8'h00, fail_valid = 0, first_fail = 3'b000, state = IDLE.
- Start accepted at edge k: vec 0 is driven from cycle k+1.
- Each vector occupies SETTLE_CYCLES + 1 cycles. The f_in sample is taken at the closing edge of its SAMPLE cycle.
- done rises at edge k + 8·(SETTLE_CYCLES+1). Default: 16 cycles after start.
- x/y/z are registered and change only on entry to SETTLE.
- rst_n low at any time, including mid-sweep: all outputs return to reset values immediately, asynchronously. The first start after release begins a fresh sweep.
- start in the same cycle as rst_n release: ignored if rst_n is still low at that edge.

## Structure
- Package `tt_pkg`: state enum (IDLE, SETTLE, SAMPLE, DONE), `TT_N_IN = 3`, `TT_WIDTH = 8`.
- One sub-module: `tt_settle_ctr`, an 8-bit loadable counter with terminal flag at SETTLE_CYCLES.
- FSM, vector register, capture and compare logic live in the top.

## Test plan
- DUT = majority(x,y,z), exp_table = 8'hE8, start → done at cycle 16; tt_out = 8'hE8, pass = 1, fail_valid = 0.
- Same DUT, exp_table = 8'hE9 → tt_out = 8'hE8, pass = 0, fail_valid = 1, first_fail = 0.
- f_in tied 1, exp_table = 8'h7F → tt_out = 8'hFF, first_fail = 7. Check x/y/z sequence 000..111 with each vector held 2 cycles.
- SETTLE_CYCLES = 3, majority DUT → done exactly 32 cycles after start. Pulse start at cycle 5 and change exp_table mid-sweep: neither has any effect.
- rst_n low during vector 4 → all outputs 0 asynchronously. Release, start → full fresh sweep, correct result.
- From DONE, start with exp_table = 8'h00, majority DUT → fail_valid cleared at restart, final first_fail = 3.

Source files
------------

// File: rtl/tt_sweep_checker_pkg.sv
// Shared types and sizes for the 3-input truth-table sweep checker.
package tt_pkg;

  localparam int TT_N_IN  = 3;
  localparam int TT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_t;

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Control/result bundle between a sweep requester and the checker.
interface tt_sweep_if;
  import tt_pkg::*;

  logic                start;
  logic [TT_WIDTH-1:0] exp_table;
  logic                busy;
  logic                done;
  logic                pass;
  logic [TT_WIDTH-1:0] tt_out;
  logic                fail_valid;
  logic [TT_N_IN-1:0]  first_fail;

  modport master (
    output start, exp_table,
    input  busy, done, pass, tt_out, fail_valid, first_fail
  );

  modport slave (
    input  start, exp_table,
    output busy, done, pass, tt_out, fail_valid, first_fail
  );

endinterface

// File: rtl/tt_sweep_checker_settle_ctr.sv
// Settle timer: cleared on load, counts while enabled, flags the last settle cycle.
module tt_settle_ctr #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic term
);

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  logic [7:0] cnt;

  // Count settle cycles since the current vector was applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= 8'd0;
    else if (load) cnt <= 8'd0;
    else if (inc)  cnt <= cnt + 8'd1;
  end

  // High during the final settle cycle, so SETTLE lasts exactly SETTLE_CYCLES.
  assign term = (cnt == LAST);

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive 3-input sweep: drives each vector, samples f_in, compares to expected.
module tt_sweep_checker
  import tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  tt_sweep_if.slave bus,
  input  logic      f_in,
  output logic      x,
  output logic      y,
  output logic      z
);

  tt_state_t           state, state_nxt;
  logic [TT_N_IN-1:0]  vec;
  logic [TT_N_IN-1:0]  first_fail;
  logic [TT_WIDTH-1:0] exp_lat;
  logic [TT_WIDTH-1:0] tt_q;
  logic                fail_q;
  logic                accept;
  logic                last_vec;
  logic                ctr_load;
  logic                ctr_inc;
  logic                settle_term;

  // Start is only honoured when no sweep is in flight.
  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign last_vec = &vec;
  assign ctr_load = accept || (state == SAMPLE && !last_vec);
  assign ctr_inc  = (state == SETTLE);

  tt_settle_ctr #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk  (clk),
    .rst_n(rst_n),
    .load (ctr_load),
    .inc  (ctr_inc),
    .term (settle_term)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: settle per vector, one sample cycle, stop after vector 7.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept)      state_nxt = SETTLE;
      SETTLE:     if (settle_term) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = last_vec ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Vector register, captured table and first-mismatch tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      tt_q       <= '0;
      exp_lat    <= '0;
      fail_q     <= 1'b0;
      first_fail <= '0;
    end else if (accept) begin
      vec        <= '0;
      tt_q       <= '0;
      exp_lat    <= bus.exp_table;
      fail_q     <= 1'b0;
      first_fail <= '0;
    end else if (state == SAMPLE) begin
      tt_q[vec] <= f_in;
      if (f_in != exp_lat[vec] && !fail_q) begin
        fail_q     <= 1'b1;
        first_fail <= vec;
      end
      if (!last_vec) vec <= vec + 3'd1;
    end
  end

  assign {x, y, z}      = vec;
  assign bus.busy       = (state == SETTLE) || (state == SAMPLE);
  assign bus.done       = (state == DONE);
  assign bus.pass       = (state == DONE) && !fail_q;
  assign bus.tt_out     = tt_q;
  assign bus.fail_valid = fail_q;
  assign bus.first_fail = first_fail;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench: two checkers (settle 1 and 3) driven in lockstep against a table-driven function.
module tb_tt_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] exp_table = 8'h00;
  logic [7:0] fn = 8'h00;
  logic       xa, ya, za, xb, yb, zb, fa, fb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tt_sweep_if ia ();
  tt_sweep_if ib ();

  assign ia.start     = start;
  assign ia.exp_table = exp_table;
  assign ib.start     = start;
  assign ib.exp_table = exp_table;

  // Function under test: a lookup on the vector each checker is driving.
  assign fa = fn[{xa, ya, za}];
  assign fb = fn[{xb, yb, zb}];

  tt_sweep_checker #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave), .f_in(fa), .x(xa), .y(ya), .z(za)
  );

  tt_sweep_checker #(.SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave), .f_in(fb), .x(xb), .y(yb), .z(zb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("miscompare on %s", tag);
    end
  endtask

  // Majority of three, built from the rule "at least two inputs high".
  function automatic logic [7:0] maj_tbl();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = ($countones(3'(i)) >= 2);
    return t;
  endfunction

  // {fail_valid, first_fail}: lowest index where function and expectation differ.
  function automatic logic [3:0] model_fail(input logic [7:0] f, input logic [7:0] e);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 7; i >= 0; i--) if (f[i] != e[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_a_ctl"}, {xa, ya, za, ia.busy, ia.done, ia.pass, ia.fail_valid, ia.first_fail}, 0);
    check({tag, "_a_tt"},  ia.tt_out, 0);
    check({tag, "_b_ctl"}, {xb, yb, zb, ib.busy, ib.done, ib.pass, ib.fail_valid, ib.first_fail}, 0);
    check({tag, "_b_tt"},  ib.tt_out, 0);
  endtask

  // One full sweep; optionally pokes start and exp_table while busy.
  task automatic run(input logic [7:0] e, input bit disturb);
    int m, la, lb;
    logic [3:0] r;
    @(negedge clk); start = 1'b1; exp_table = e;
    @(negedge clk); start = 1'b0;
    m = 0; la = -1; lb = -1;
    check("clear_a", {ia.done, ia.pass, ia.fail_valid, ia.first_fail, ia.tt_out}, 0);
    check("clear_b", {ib.done, ib.pass, ib.fail_valid, ib.first_fail, ib.tt_out}, 0);
    while (m < 100) begin
      if (ia.done && la < 0) la = m;
      if (ib.done && lb < 0) lb = m;
      if (la >= 0 && lb >= 0) break;
      if (!ia.done) check("xyz_a", {ia.busy, xa, ya, za}, {1'b1, 3'(m / 2)});
      if (!ib.done) check("xyz_b", {ib.busy, xb, yb, zb}, {1'b1, 3'(m / 4)});
      if (disturb && m == 5) begin start = 1'b1; exp_table = ~e; end
      if (disturb && m == 6) start = 1'b0;
      @(negedge clk); m++;
    end
    check("lat_a", la, 16);
    check("lat_b", lb, 32);
    r = model_fail(fn, e);
    check("tt_a",  ia.tt_out, fn);
    check("res_a", {ia.done, ia.busy, ia.pass, ia.fail_valid, ia.first_fail, xa, ya, za},
          {1'b1, 1'b0, ~r[3], r[3], r[2:0], 3'd7});
    check("tt_b",  ib.tt_out, fn);
    check("res_b", {ib.done, ib.busy, ib.pass, ib.fail_valid, ib.first_fail, xb, yb, zb},
          {1'b1, 1'b0, ~r[3], r[3], r[2:0], 3'd7});
  endtask

  initial begin
    logic [7:0] e;
    #1 check_idle("reset");
    #11 rst_n = 1'b1;
    @(negedge clk) check_idle("post_reset");

    fn = maj_tbl(); run(8'hE8, 1'b0);
    run(8'hE9, 1'b0);
    fn = 8'hFF;     run(8'h7F, 1'b0);
    fn = maj_tbl(); run(8'hE8, 1'b1);

    // Asynchronous reset while checker A is on vector 4.
    @(negedge clk); start = 1'b1; exp_table = 8'hE8;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk); rst_n = 1'b1;
    check_idle("rst_release");
    run(8'hE8, 1'b0);
    run(8'h00, 1'b0);

    // Start coincident with an edge while still in reset is dropped.
    @(negedge clk); rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1; start = 1'b0;
    @(negedge clk) check_idle("start_in_rst");
    @(negedge clk) check_idle("start_in_rst2");

    for (int k = 0; k < 8; k++) begin
      fn = 8'($urandom);
      e  = ($urandom_range(0, 2) == 0) ? fn : 8'($urandom);
      run(e, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
